// File: rtl/cache_pkg.sv
// cache_pkg: shared constants, fill FSM state type and block-base helper for the cache fill controller
package cache_pkg;
   localparam int BLOCK_WORDS = 8;
   localparam int ADDR_W      = 16;
   localparam int IDX_W       = $clog2(BLOCK_WORDS);
   localparam int CNT_W       = IDX_W + 1;
   localparam int OFFSET_BITS = IDX_W + 1;
   typedef enum logic {IDLE, FILL} fillState_t;
   function automatic logic [ADDR_W-1:0] blockBase(input logic [ADDR_W-1:0] addr);
      return addr & ~ADDR_W'(2 * BLOCK_WORDS - 1);
   endfunction
endpackage

// File: rtl/fill_counter.sv
// fill_counter: saturating beat counter (0..BLOCK_WORDS) with clear/increment and rotated word index
//   clk, rst : clock, async active-high reset
//   clr, inc : clear (wins) / increment, holds at BLOCK_WORDS
//   start    : word offset the rotation begins at
//   count    : beats counted so far
//   idx      : (start + count) modulo BLOCK_WORDS
module fill_counter
   import cache_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   input  logic [IDX_W-1:0] start,
   output logic [CNT_W-1:0] count,
   output logic [IDX_W-1:0] idx
);
   always_ff @(posedge clk or posedge rst)
      if (rst) count <= '0;
      else if (clr) count <= '0;
      else if (inc && count < CNT_W'(BLOCK_WORDS)) count <= count + CNT_W'(1);
   assign idx = start + count[IDX_W-1:0];
endmodule

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: miss handler that stalls the pipeline and streams one block from memory into the cache
//   clk, rst           : clock, async active-high reset
//   miss_detected      : lookup missed this cycle; miss_address is the missing byte address
//   memory_data_valid  : a returning word is on memory_data (data itself goes straight to the array)
//   fsm_busy           : pipeline stall, asserted combinationally in the miss cycle
//   mem_read_en        : read issued this cycle at memory_address
//   write_data_array   : write the returning word at fill_word_idx
//   write_tag_array    : tag/valid write, with fill_done, on the final beat
// Build option: CACHE_FILL_CRITICAL_WORD_FIRST_EN starts issue/receive order at the missing word.
module cache_fill_fsm
   import cache_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              miss_detected,
   input  logic [ADDR_W-1:0] miss_address,
   input  logic              memory_data_valid,
   input  logic [15:0]       memory_data,
   output logic              fsm_busy,
   output logic              mem_read_en,
   output logic [ADDR_W-1:0] memory_address,
   output logic              write_data_array,
   output logic [IDX_W-1:0]  fill_word_idx,
   output logic              write_tag_array,
   output logic              fill_done
);
   fillState_t        state;
   logic [ADDR_W-1:0] baseAddr;
   logic [IDX_W-1:0]  startOff, missOff, issueIdx, recvIdx;
   logic [CNT_W-1:0]  issueCnt, recvCnt;
   logic              isFill, startMiss, lastBeat, unusedBits;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
   assign missOff = miss_address[IDX_W:1];
`else
   assign missOff = '0;
`endif
   // returning data bypasses this block; low address bits are only a word/byte offset
   assign unusedBits       = ^{memory_data, miss_address[OFFSET_BITS-1:0]};
   assign isFill           = state == FILL;
   assign startMiss        = state == IDLE && miss_detected;
   assign fsm_busy         = isFill || startMiss;
   assign mem_read_en      = isFill && issueCnt < CNT_W'(BLOCK_WORDS);
   assign memory_address   = mem_read_en ? baseAddr | ADDR_W'({issueIdx, 1'b0}) : '0;
   assign write_data_array = isFill && memory_data_valid;
   assign fill_word_idx    = write_data_array ? recvIdx : '0;
   assign lastBeat         = write_data_array && recvCnt == CNT_W'(BLOCK_WORDS - 1);
   assign write_tag_array  = lastBeat;
   assign fill_done        = lastBeat;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state    <= IDLE;
         baseAddr <= '0;
         startOff <= '0;
      end else if (startMiss) begin
         state    <= FILL;
         baseAddr <= blockBase(miss_address);
         startOff <= missOff;
      end else if (lastBeat) state <= IDLE;
   fill_counter issueCtr (
      .clk   (clk),
      .rst   (rst),
      .clr   (startMiss),
      .inc   (isFill),
      .start (startOff),
      .count (issueCnt),
      .idx   (issueIdx)
   );
   fill_counter recvCtr (
      .clk   (clk),
      .rst   (rst),
      .clr   (startMiss),
      .inc   (write_data_array),
      .start (startOff),
      .count (recvCnt),
      .idx   (recvIdx)
   );
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: table-driven and scoreboarded checks of the cache fill controller
module tb_cache_fill_fsm;
   import cache_pkg::*;
   logic        clk = 1'b0;
   logic        rst, missDetected, memVld;
   logic [15:0] missAddr, memData;
   logic        fsm_busy, mem_read_en, write_data_array, write_tag_array, fill_done;
   logic [15:0] memory_address;
   logic [2:0]  fill_word_idx;
   int          passCnt = 0, totalCnt = 0;

   typedef struct {logic [2:0] idx; logic tag;} beat_t;
   typedef struct {
      logic miss; logic [15:0] addr; logic vld;
      logic busy; logic rd; logic [15:0] maddr; logic wr; logic [2:0] idx; logic tag;
   } vec_t;
   beat_t sb[$];
   vec_t  tbl[14];

   always #5 clk = ~clk;

   cache_fill_fsm dut (
      .clk               (clk),
      .rst               (rst),
      .miss_detected     (missDetected),
      .miss_address      (missAddr),
      .memory_data_valid (memVld),
      .memory_data       (memData),
      .fsm_busy          (fsm_busy),
      .mem_read_en       (mem_read_en),
      .memory_address    (memory_address),
      .write_data_array  (write_data_array),
      .fill_word_idx     (fill_word_idx),
      .write_tag_array   (write_tag_array),
      .fill_done         (fill_done)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      totalCnt++;
      if (act === exp) passCnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [2:0] startOf(input logic [15:0] a);
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
      return a[3:1];
`else
      return 3'd0;
`endif
   endfunction

   function automatic logic [31:0] latSched(input int lat);
      return 32'hFF << (1 + lat);
   endfunction

   task automatic drive(input logic m, input logic [15:0] a, input logic v);
      @(posedge clk);
      #1;
      missDetected = m;
      missAddr     = a;
      memVld       = v;
      memData      = 16'($urandom);
      @(negedge clk);
   endtask

   task automatic idleChk(input string tag);
      drive(1'b0, 16'h0000, 1'b0);
      chk({tag, "_busy"}, fsm_busy, 1'b0);
      chk({tag, "_rd"}, mem_read_en, 1'b0);
      chk({tag, "_wr"}, write_data_array, 1'b0);
   endtask

   // one complete fill: miss in cycle 0, valid beats where sched has a bit set, last beat in cycle 'last'
   task automatic runSeq(input string name, input logic [15:0] a, input logic [31:0] sched,
                         input int last, input bit hold);
      logic [15:0] base = a & 16'hFFF0;
      logic [2:0]  s    = startOf(a);
      int          beats = 0;
      for (int c = 0; c <= last; c++) begin
         bit v     = c > 0 && sched[c];
         bit lastV = v && beats == 7;
         if (v) begin
            sb.push_back('{idx: s + 3'(beats), tag: beats == 7});
            beats++;
         end
         drive(c == 0 || hold, c == 0 ? a : 16'($urandom), v);
         chk($sformatf("%s_c%0d_busy", name, c), fsm_busy, 1'b1);
         chk($sformatf("%s_c%0d_rd", name, c), mem_read_en, c >= 1 && c <= 8);
         if (c >= 1 && c <= 8)
            chk($sformatf("%s_c%0d_maddr", name, c), memory_address,
                base + 16'(2 * ((int'(s) + c - 1) % 8)));
         chk($sformatf("%s_c%0d_wr", name, c), write_data_array, v);
         if (write_data_array) begin
            if (sb.size() == 0) begin
               totalCnt++;
               $display("FAIL %s_c%0d_sb: data write with no beat pending", name, c);
            end else begin
               beat_t e = sb.pop_front();
               chk($sformatf("%s_c%0d_idx", name, c), fill_word_idx, e.idx);
               chk($sformatf("%s_c%0d_tag", name, c), write_tag_array, e.tag);
            end
         end else chk($sformatf("%s_c%0d_tag", name, c), write_tag_array, 1'b0);
         chk($sformatf("%s_c%0d_done", name, c), fill_done, lastV);
      end
      chk({name, "_sb_drained"}, sb.size(), 0);
      sb.delete();
   endtask

   initial begin
      logic [31:0] irr;
      int s;
      rst = 1'b1; missDetected = 1'b0; missAddr = 16'h0; memVld = 1'b0; memData = 16'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", fsm_busy, 1'b0);
      chk("rst_rd", mem_read_en, 1'b0);
      chk("rst_maddr", memory_address, 16'h0);
      chk("rst_wr", write_data_array, 1'b0);
      chk("rst_idx", fill_word_idx, 3'd0);
      chk("rst_tag", write_tag_array, 1'b0);
      chk("rst_done", fill_done, 1'b0);
      missDetected = 1'b1;
      #1;
      chk("rst_busy_miss", fsm_busy, 1'b1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      missDetected = 1'b0;
      @(negedge clk);
      chk("post_rst_busy", fsm_busy, 1'b0);

      // miss at 0x1236, 4-cycle memory latency, address input scribbled during the fill
      s = int'(startOf(16'h1236));
      for (int c = 0; c < 14; c++) begin
         tbl[c].miss  = c == 0;
         tbl[c].addr  = c == 0 ? 16'h1236 : 16'hBEEF;
         tbl[c].vld   = c >= 5 && c <= 12;
         tbl[c].busy  = c <= 12;
         tbl[c].rd    = c >= 1 && c <= 8;
         tbl[c].maddr = 16'h1230 + 16'(2 * ((s + c - 1) % 8));
         tbl[c].wr    = tbl[c].vld;
         tbl[c].idx   = 3'((s + c - 5) % 8);
         tbl[c].tag   = c == 12;
      end
      for (int c = 0; c < 14; c++) begin
         drive(tbl[c].miss, tbl[c].addr, tbl[c].vld);
         chk($sformatf("tbl%0d_busy", c), fsm_busy, tbl[c].busy);
         chk($sformatf("tbl%0d_rd", c), mem_read_en, tbl[c].rd);
         if (tbl[c].rd) chk($sformatf("tbl%0d_maddr", c), memory_address, tbl[c].maddr);
         chk($sformatf("tbl%0d_wr", c), write_data_array, tbl[c].wr);
         if (tbl[c].wr) chk($sformatf("tbl%0d_idx", c), fill_word_idx, tbl[c].idx);
         chk($sformatf("tbl%0d_tag", c), write_tag_array, tbl[c].tag);
         chk($sformatf("tbl%0d_done", c), fill_done, tbl[c].tag);
      end

      // irregular returns: beats on cycles 5,7,8,11,12,13,15,16
      irr = 32'h0;
      irr[5] = 1'b1; irr[7] = 1'b1; irr[8] = 1'b1; irr[11] = 1'b1;
      irr[12] = 1'b1; irr[13] = 1'b1; irr[15] = 1'b1; irr[16] = 1'b1;
      runSeq("irr", 16'h0ACE, irr, 16, 1'b0);
      idleChk("irr_end");

      // reset in cycle 7 of a fill
      drive(1'b1, 16'h1236, 1'b0);
      for (int c = 1; c < 7; c++) begin
         drive(1'b0, 16'h1236, c >= 5);
         chk($sformatf("abort_c%0d_tag", c), write_tag_array, 1'b0);
      end
      @(posedge clk);
      #1;
      missDetected = 1'b0;
      memVld = 1'b1;
      rst = 1'b1;
      #1;
      chk("abort_busy", fsm_busy, 1'b0);
      chk("abort_rd", mem_read_en, 1'b0);
      chk("abort_maddr", memory_address, 16'h0);
      chk("abort_wr", write_data_array, 1'b0);
      chk("abort_idx", fill_word_idx, 3'd0);
      chk("abort_tag", write_tag_array, 1'b0);
      chk("abort_done", fill_done, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      memVld = 1'b0;
      @(negedge clk);
      chk("abort_after_busy", fsm_busy, 1'b0);
      chk("abort_after_tag", write_tag_array, 1'b0);
      runSeq("restart", 16'h1236, latSched(1), 9, 1'b0);
      idleChk("restart_end");

      // valid beats while idle must be ignored
      for (int c = 0; c < 2; c++) begin
         drive(1'b0, 16'h0000, 1'b1);
         chk($sformatf("idlev%0d_wr", c), write_data_array, 1'b0);
         chk($sformatf("idlev%0d_busy", c), fsm_busy, 1'b0);
         chk($sformatf("idlev%0d_tag", c), write_tag_array, 1'b0);
      end
      runSeq("after_idlev", 16'h4A5C, latSched(2), 10, 1'b0);
      idleChk("after_idlev_end");

      // miss held high through a fill, second miss picked up in cycle 13
      runSeq("hold1", 16'h1236, latSched(4), 12, 1'b1);
      runSeq("hold2", 16'h5678, latSched(3), 11, 1'b0);
      idleChk("hold_end");

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end
endmodule
